// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer_pkg
//  Purpose  : Shared instruction-field positions, opcode encodings and state
//             types for the Colorus fetch sequencer and its return stack.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_sequencer_pkg;

    localparam int INSTR_W = 28;

    // Instruction field positions
    localparam int OPC_MSB = 27;
    localparam int OPC_LSB = 24;
    localparam int TGT_MSB = 23;
    localparam int TGT_LSB = 16;

    typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;

    // Opcode encodings
    localparam opcode_t OPC_NOP   = 4'h0;
    localparam opcode_t OPC_STO   = 4'h1;
    localparam opcode_t OPC_ADD   = 4'h2;
    localparam opcode_t OPC_SUB   = 4'h3;
    localparam opcode_t OPC_JMP   = 4'h4;
    localparam opcode_t OPC_BLE   = 4'h5;
    localparam opcode_t OPC_WVM   = 4'h6;
    localparam opcode_t OPC_LED   = 4'h7;
    localparam opcode_t OPC_CALL  = 4'h8;
    localparam opcode_t OPC_RET   = 4'h9;
    localparam opcode_t OPC_MOVSP = 4'hA;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } seq_state_t;

    typedef enum logic [1:0] {
        FC_NONE      = 2'b00,
        FC_OVERFLOW  = 2'b01,
        FC_UNDERFLOW = 2'b10
    } fault_code_t;

    function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_return_stack.sv
`default_nettype none
// ============================================================================
//  Module   : return_stack
//  Purpose  : LIFO of return addresses. Registered storage indexed by a
//             depth pointer; overflow/underflow policy belongs to the user.
//  Revision : 1.0  initial release
// ============================================================================
module return_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     iPush,
    input  logic                     iPop,
    input  logic [WIDTH-1:0]         iData,
    output logic [WIDTH-1:0]         oTop,
    output logic [$clog2(DEPTH):0]   oDepth,
    output logic                     oFull,
    output logic                     oEmpty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   depth_q;
    logic [PTR_W-1:0] top_idx;

    assign oFull   = (depth_q == (PTR_W+1)'(DEPTH));
    assign oEmpty  = (depth_q == '0);
    assign oDepth  = depth_q;
    // Index of the newest entry; the value read while empty is never consumed.
    assign top_idx = depth_q[PTR_W-1:0] - PTR_W'(1);
    assign oTop    = mem_q[top_idx];

    // Depth pointer: push grows, pop shrinks, reset empties the stack.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            depth_q <= '0;
        end else if (iPush && !oFull) begin
            depth_q <= depth_q + (PTR_W+1)'(1);
        end else if (iPop && !oEmpty) begin
            depth_q <= depth_q - (PTR_W+1)'(1);
        end
    end

    // Entry storage: write the pushed address into the next free slot.
    always_ff @(posedge Clock) begin
        if (Reset && iPush && !oFull) begin
            mem_q[depth_q[PTR_W-1:0]] <= iData;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Program counter and control-flow sequencer. Drives the ROM
//             address, resolves JMP/CALL/RET/BLE locally using a hardware
//             return stack, and halts in FAULT on stack over/underflow.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [INSTR_W-1:0]             iInstruction,
    input  logic                           iBranchTaken,
    input  logic                           iStall,
    output logic [ADDR_W-1:0]              oAddress,
    output logic [INSTR_W-1:0]             oInstruction,
    output logic [$clog2(STACK_DEPTH):0]   oStackDepth,
    output logic                           oFault,
    output logic [1:0]                     oFaultCode
);

    localparam logic [INSTR_W-1:0] NOP_WORD = {OPC_NOP, 24'd0};

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] stack_top;
    seq_state_t        state_q;
    seq_state_t        state_d;
    fault_code_t       code_q;
    fault_code_t       code_d;
    logic              fault_q;
    logic              push;
    logic              pop;
    logic              stack_full;
    logic              stack_empty;
    opcode_t           opcode;

    assign opcode = get_opcode(iInstruction);
    // Target is an 8-bit absolute address, zero-extended to the PC width.
    assign target = ADDR_W'(iInstruction[TGT_MSB:TGT_LSB]);
    // Modular increment: the top of the address space wraps silently to 0.
    assign pc_inc = pc_q + ADDR_W'(1);

    return_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .Clock  (Clock),
        .Reset  (Reset),
        .iPush  (push),
        .iPop   (pop),
        .iData  (pc_inc),
        .oTop   (stack_top),
        .oDepth (oStackDepth),
        .oFull  (stack_full),
        .oEmpty (stack_empty)
    );

    // Next-PC selection, stack requests and fault detection for one opcode.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        code_d  = code_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (state_q == ST_RUN && !iStall) begin
            case (opcode)
                OPC_JMP: pc_d = target;
                OPC_CALL: begin
                    if (!stack_full) begin
                        push = 1'b1;
                        pc_d = target;
                    end else begin
                        state_d = ST_FAULT;
                        code_d  = FC_OVERFLOW;
                    end
                end
                OPC_RET: begin
                    if (!stack_empty) begin
                        pop  = 1'b1;
                        pc_d = stack_top;
                    end else begin
                        state_d = ST_FAULT;
                        code_d  = FC_UNDERFLOW;
                    end
                end
                OPC_BLE: pc_d = iBranchTaken ? target : pc_inc;
                default: pc_d = pc_inc;
            endcase
        end
    end

    // RUN/FAULT state machine with registered PC and fault outputs.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            pc_q    <= '0;
            state_q <= ST_RUN;
            code_q  <= FC_NONE;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            code_q  <= code_d;
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign oAddress     = pc_q;
    assign oFault       = fault_q;
    assign oFaultCode   = code_q;
    // A halted sequencer feeds NOPs so execute performs no writes.
    assign oInstruction = fault_q ? NOP_WORD : iInstruction;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Purpose  : Directed self-checking bench for fetch_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (16-bit PC, 8-entry stack)
    logic        rst_n;
    logic [27:0] instr;
    logic        bt;
    logic        stall;
    logic [15:0] addr;
    logic [27:0] oinstr;
    logic [3:0]  depth;
    logic        fault;
    logic [1:0]  fcode;

    // Small instance (8-bit PC, 2-entry stack) for wrap checks
    logic        rst_nb;
    logic [27:0] instr_b;
    logic [7:0]  addr_b;
    logic [27:0] oinstr_b;
    logic [1:0]  depth_b;
    logic        fault_b;
    logic [1:0]  fcode_b;

    int n_checks = 0;
    int n_errors = 0;

    fetch_sequencer #(.ADDR_W(16), .STACK_DEPTH(8)) dut (
        .Clock        (clk),
        .Reset        (rst_n),
        .iInstruction (instr),
        .iBranchTaken (bt),
        .iStall       (stall),
        .oAddress     (addr),
        .oInstruction (oinstr),
        .oStackDepth  (depth),
        .oFault       (fault),
        .oFaultCode   (fcode)
    );

    fetch_sequencer #(.ADDR_W(8), .STACK_DEPTH(2)) dut_b (
        .Clock        (clk),
        .Reset        (rst_nb),
        .iInstruction (instr_b),
        .iBranchTaken (1'b0),
        .iStall       (1'b0),
        .oAddress     (addr_b),
        .oInstruction (oinstr_b),
        .oStackDepth  (depth_b),
        .oFault       (fault_b),
        .oFaultCode   (fcode_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] mk(input logic [3:0] op, input logic [7:0] tgt);
        return {op, tgt, 16'h0000};
    endfunction

    task automatic step(input logic [27:0] ins, input logic b, input logic s);
        instr = ins;
        bt    = b;
        stall = s;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic [27:0] ins);
        instr_b = ins;
        @(posedge clk);
        #1;
    endtask

    logic [27:0] nop_w;

    initial begin
        nop_w   = mk(OPC_NOP, 8'h00);
        rst_nb  = 1'b0;
        instr_b = nop_w;

        // Reset with a CALL presented: reset wins
        rst_n = 1'b0;
        step(mk(OPC_CALL, 8'h55), 1'b0, 1'b0);
        step(mk(OPC_CALL, 8'h55), 1'b0, 1'b0);
        check("rst_pc", addr, 32'h0);
        check("rst_depth", depth, 32'h0);
        check("rst_fault", fault, 32'h0);
        check("rst_code", fcode, 32'h0);
        rst_n = 1'b1;

        // Straight-line code and stall
        step(nop_w, 1'b0, 1'b0);
        check("seq_pc1", addr, 32'h1);
        step(nop_w, 1'b0, 1'b0);
        check("seq_pc2", addr, 32'h2);
        for (int i = 0; i < 3; i++) begin
            step(nop_w, 1'b0, 1'b1);
            check("stall_pc", addr, 32'h2);
        end
        step(mk(OPC_CALL, 8'h40), 1'b0, 1'b1);
        check("stall_call_pc", addr, 32'h2);
        check("stall_call_depth", depth, 32'h0);
        check("stall_passthru", oinstr, 32'h08400000);
        step(nop_w, 1'b0, 1'b0);
        check("seq_pc3", addr, 32'h3);
        step(nop_w, 1'b0, 1'b0);
        step(nop_w, 1'b0, 1'b0);
        check("seq_pc5", addr, 32'h5);

        // CALL / RET
        step(mk(OPC_CALL, 8'h20), 1'b0, 1'b0);
        check("call_pc", addr, 32'h20);
        check("call_depth", depth, 32'h1);
        step(nop_w, 1'b0, 1'b0);
        step(nop_w, 1'b0, 1'b0);
        step(nop_w, 1'b0, 1'b0);
        check("sub_pc23", addr, 32'h23);
        step(mk(OPC_RET, 8'h00), 1'b0, 1'b0);
        check("ret_pc", addr, 32'h6);
        check("ret_depth", depth, 32'h0);

        // BLE and JMP
        step(mk(OPC_JMP, 8'h10), 1'b0, 1'b0);
        check("jmp_pc10", addr, 32'h10);
        step(mk(OPC_BLE, 8'h0F), 1'b1, 1'b0);
        check("ble_taken", addr, 32'h0F);
        step(nop_w, 1'b0, 1'b0);
        step(mk(OPC_BLE, 8'h0F), 1'b0, 1'b0);
        check("ble_not_taken", addr, 32'h11);
        step(nop_w, 1'b1, 1'b0);
        check("bt_ignored", addr, 32'h12);
        step(mk(OPC_JMP, 8'h18), 1'b0, 1'b0);
        check("jmp_pc18", addr, 32'h18);
        step(mk(OPC_JMP, 8'h17), 1'b0, 1'b0);
        check("jmp_back", addr, 32'h17);
        step(nop_w, 1'b0, 1'b0);
        step(mk(OPC_JMP, 8'h17), 1'b0, 1'b0);
        check("jmp_repeat", addr, 32'h17);

        // Mid-program reset at PC=0x11, depth=3
        step(mk(OPC_CALL, 8'h30), 1'b0, 1'b0);
        step(mk(OPC_CALL, 8'h40), 1'b0, 1'b0);
        step(mk(OPC_CALL, 8'h10), 1'b0, 1'b0);
        step(nop_w, 1'b0, 1'b0);
        check("mid_pc", addr, 32'h11);
        check("mid_depth", depth, 32'h3);
        rst_n = 1'b0;
        step(mk(OPC_RET, 8'h00), 1'b0, 1'b0);
        check("mid_rst_pc", addr, 32'h0);
        check("mid_rst_depth", depth, 32'h0);
        check("mid_rst_fault", fault, 32'h0);
        step(mk(OPC_RET, 8'h00), 1'b0, 1'b0);
        rst_n = 1'b1;

        // Overflow: nine nested CALLs
        for (int i = 0; i < 8; i++) begin
            step(mk(OPC_CALL, 8'h01), 1'b0, 1'b0);
        end
        check("ovf_depth8", depth, 32'h8);
        check("ovf_pre_fault", fault, 32'h0);
        step(mk(OPC_CALL, 8'h01), 1'b0, 1'b0);
        check("ovf_fault", fault, 32'h1);
        check("ovf_code", fcode, 32'h1);
        check("ovf_pc", addr, 32'h1);
        check("ovf_depth", depth, 32'h8);
        check("ovf_nop", oinstr, 32'h00000000);
        step(mk(OPC_JMP, 8'h33), 1'b0, 1'b0);
        check("ovf_frozen", addr, 32'h1);
        check("ovf_sticky", fault, 32'h1);

        // Underflow after reset
        rst_n = 1'b0;
        step(nop_w, 1'b0, 1'b0);
        check("flt_rst", fault, 32'h0);
        rst_n = 1'b1;
        step(mk(OPC_RET, 8'h00), 1'b0, 1'b0);
        check("udf_fault", fault, 32'h1);
        check("udf_code", fcode, 32'h2);
        check("udf_pc", addr, 32'h0);

        // Walk to the top of the 16-bit space; CALL there pushes 0x0000
        rst_n = 1'b0;
        step(nop_w, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(mk(OPC_JMP, 8'hFF), 1'b0, 1'b0);
        repeat (16'hFFFF - 16'h00FF) step(nop_w, 1'b0, 1'b0);
        check("top_pc", addr, 32'hFFFF);
        step(mk(OPC_CALL, 8'h40), 1'b0, 1'b0);
        check("top_call_pc", addr, 32'h40);
        check("top_call_depth", depth, 32'h1);
        step(mk(OPC_RET, 8'h00), 1'b0, 1'b0);
        check("top_ret_wrap", addr, 32'h0);
        check("top_ret_depth", depth, 32'h0);

        // 8-bit instance: increment wrap, return-address wrap, small overflow
        rst_nb = 1'b1;
        step_b(mk(OPC_JMP, 8'hFF));
        check("b_jmp_ff", addr_b, 32'hFF);
        step_b(nop_w);
        check("b_inc_wrap", addr_b, 32'h00);
        step_b(mk(OPC_JMP, 8'hFF));
        step_b(mk(OPC_CALL, 8'h10));
        check("b_call_pc", addr_b, 32'h10);
        step_b(mk(OPC_RET, 8'h00));
        check("b_ret_wrap", addr_b, 32'h00);
        step_b(mk(OPC_CALL, 8'h20));
        step_b(mk(OPC_CALL, 8'h30));
        check("b_depth2", depth_b, 32'h2);
        step_b(mk(OPC_CALL, 8'h40));
        check("b_ovf_fault", fault_b, 32'h1);
        check("b_ovf_code", fcode_b, 32'h1);
        check("b_ovf_pc", addr_b, 32'h30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
